id_branch_predict: RTL and testbench

- ID-stage branch predictor and target generator. It sits directly downstream of the fetch stage.
- It decodes the instruction fetched at id_pc, produces id_target and id_target_taken for fetch redirection, and carries the prediction into EX.
- EX reports branch outcomes back to it. It trains a table of 2-bit saturating counters, raises ex_br_mispred, and supplies the corrected redirect PC.

---
 rtl/id_branch_predict_pkg.sv | 33 +++
 rtl/id_branch_predict_bht_counter_table.sv | 39 +++
 rtl/id_branch_predict.sv | 127 ++++++++++++
 tb/tb_id_branch_predict.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_branch_predict_pkg.sv
// Shared decode constants, counter encodings and immediate extraction for the ID branch predictor.
// Latency/backpressure: none (definitions only).
package id_branch_predict_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != ST)
      nxt = cnt + 2'd1;
    else if (!taken && cnt != SNT)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/id_branch_predict_bht_counter_table.sv
// Array of 2-bit saturating counters: combinational read, write lands at the clock edge (no bypass).
// Backpressure: none; the caller gates wr_en.
module id_branch_predict_bht_counter_table
  import id_branch_predict_pkg::*;
#(
  parameter int          ENTRIES = 64,
  parameter logic [1:0]  INIT    = 2'b01,
  localparam int         IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d [ENTRIES];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en)
      cnt_d[wr_idx] = sat_update(cnt_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt_q[i] <= INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/id_branch_predict.sv
// ID-stage branch predictor/target generator; prediction reaches EX one cycle later via pred_q, mispredict is combinational.
// Backpressure: id_stall/ex_stall hold pred_q and training; optional BP_STATS_EN adds event counters.
module id_branch_predict
  import id_branch_predict_pkg::*;
#(
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stall,
  input  logic        ex_stall,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  output logic [31:0] id_target,
  output logic        id_target_taken,
  input  logic        ex_is_branch,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_br_target,
  output logic        ex_br_mispred,
  output logic [31:0] ex_redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred,
  output logic [31:0] stat_jal
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [6:0] opcode;
  logic       is_br;
  logic       is_jal;
  logic [1:0] bht_rd_cnt;
  logic       pred_taken;
  logic       train_en;
  logic       pred_q;
  logic       pred_d;

  assign opcode = id_inst[6:0];
  assign is_br  = (opcode == OPC_BRANCH);
  assign is_jal = (opcode == OPC_JAL);

  id_branch_predict_bht_counter_table #(
    .ENTRIES (BHT_ENTRIES),
    .INIT    (BHT_INIT)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (id_pc[IDX_W+1:2]),
    .rd_cnt   (bht_rd_cnt),
    .wr_en    (train_en),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_br_taken)
  );

  always_comb begin
    id_target  = id_pc + 32'd4;
    pred_taken = 1'b0;
    if (is_br) begin
      id_target  = id_pc + b_imm(id_inst);
      pred_taken = bht_rd_cnt[1];
    end else if (is_jal) begin
      id_target  = id_pc + j_imm(id_inst);
      pred_taken = 1'b1;
    end
  end

  // The older EX redirect flushes ID, so it suppresses the ID redirect.
  assign id_target_taken = id_valid & pred_taken & ~ex_br_mispred;
  assign ex_br_mispred   = ex_is_branch & (ex_br_taken != pred_q);
  assign ex_redirect_pc  = ex_br_taken ? ex_br_target : ex_pc + 32'd4;
  assign train_en        = ex_is_branch & ~ex_stall;

  always_comb begin
    pred_d = pred_q;
    if (ex_br_mispred && !ex_stall)
      pred_d = 1'b0;
    else if (!id_stall && !ex_stall)
      pred_d = id_valid & is_br & pred_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pred_q <= 1'b0;
    else
      pred_q <= pred_d;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;
  logic [31:0] stat_jal_q,      stat_jal_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    stat_jal_d      = stat_jal_q;
    if (train_en)
      stat_branches_d = stat_branches_q + 32'd1;
    if (ex_br_mispred && !ex_stall)
      stat_mispred_d = stat_mispred_q + 32'd1;
    if (id_target_taken && is_jal && !id_stall && !ex_stall)
      stat_jal_d = stat_jal_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
      stat_jal_q      <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
      stat_jal_q      <= stat_jal_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
  assign stat_jal      = stat_jal_q;
`endif

endmodule

// File: tb/tb_id_branch_predict.sv
// Directed bench for id_branch_predict: expectations queued when stimulus is driven, popped at the sample point.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_id_branch_predict;

  logic        clk;
  logic        rst_n;
  logic        id_stall, ex_stall;
  logic [31:0] id_pc, id_inst;
  logic        id_valid;
  logic [31:0] id_target;
  logic        id_target_taken;
  logic        ex_is_branch, ex_br_taken;
  logic [31:0] ex_pc, ex_br_target;
  logic        ex_br_mispred;
  logic [31:0] ex_redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispred, stat_jal;
`endif

  id_branch_predict dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_stall        (id_stall),
    .ex_stall        (ex_stall),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_valid        (id_valid),
    .id_target       (id_target),
    .id_target_taken (id_target_taken),
    .ex_is_branch    (ex_is_branch),
    .ex_br_taken     (ex_br_taken),
    .ex_pc           (ex_pc),
    .ex_br_target    (ex_br_target),
    .ex_br_mispred   (ex_br_mispred),
    .ex_redirect_pc  (ex_redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred),
    .stat_jal        (stat_jal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] PC_A = 32'h4000_0010;
  localparam logic [31:0] T_A  = 32'h4000_0020;
  localparam logic [31:0] PC_B = 32'h4000_0100;

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6f};
  endfunction

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=<nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic id_drv(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    id_valid = v;
    id_pc    = pc;
    id_inst  = inst;
  endtask

  task automatic ex_drv(input logic br, input logic tk, input logic stall,
                        input logic [31:0] pc, input logic [31:0] tgt);
    ex_is_branch = br;
    ex_br_taken  = tk;
    ex_stall     = stall;
    ex_pc        = pc;
    ex_br_target = tgt;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] br_a, br_b, jal_b, jalr_b;
    br_a   = enc_b(13'd16);
    br_b   = enc_b(13'h1FE0);
    jal_b  = enc_j(21'h1FFFF8);
    jalr_b = 32'h0000_0067;

    rst_n = 1'b0;
    id_stall = 1'b0;
    id_drv(1'b0, '0, '0);
    ex_drv(1'b0, 1'b0, 1'b0, '0, '0);

    // In reset: branch decode, table at init, mispred follows ex_br_taken
    #1;
    id_drv(1'b1, PC_A, br_a);
    ex_drv(1'b1, 1'b1, 1'b0, PC_A, T_A);
    push("rst_br_target", T_A);
    push("rst_br_taken", 32'd0);
    push("rst_mispred_tk", 32'd1);
    push("rst_cnt4", 32'd1);
    push("rst_redirect_tk", T_A);
    @(negedge clk);
    pop_chk(id_target);
    pop_chk({31'd0, id_target_taken});
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk(ex_redirect_pc);

    ex_drv(1'b1, 1'b0, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_B, jal_b);
    push("rst_mispred_nt", 32'd0);
    push("rst_jal_taken", 32'd1);
    push("rst_redirect_nt", 32'h4000_0014);
    #1;
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({31'd0, id_target_taken});
    pop_chk(ex_redirect_pc);

    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    nxt();
    rst_n = 1'b1;

    // Branch in ID, untrained
    id_drv(1'b1, PC_A, br_a);
    push("br_target", T_A);
    push("br_taken_init", 32'd0);
    push("cnt_init", 32'd1);
    @(negedge clk);
    pop_chk(id_target);
    pop_chk({31'd0, id_target_taken});
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});

    // Train taken twice
    nxt();
    id_drv(1'b0, PC_A, br_a);
    ex_drv(1'b1, 1'b1, 1'b0, PC_A, T_A);
    push("tr1_mispred", 32'd1);
    push("tr1_redirect", T_A);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk(ex_redirect_pc);
    nxt();
    push("tr2_cnt", 32'd2);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});

    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_A, br_a);
    push("tr_cnt_st", 32'd3);
    push("br_taken_st", 32'd1);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk({31'd0, id_target_taken});

    // Third taken: correctly predicted, counter saturates
    nxt();
    id_drv(1'b0, PC_A, br_a);
    ex_drv(1'b1, 1'b1, 1'b0, PC_A, T_A);
    push("tr3_mispred", 32'd0);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});

    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_A, br_a);
    push("sat_cnt", 32'd3);
    push("sat_taken", 32'd1);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk({31'd0, id_target_taken});

    // Mispredict: EX not-taken while ID branch predicted taken
    nxt();
    ex_drv(1'b1, 1'b0, 1'b0, PC_A, T_A);
    push("mp_mispred", 32'd1);
    push("mp_redirect", 32'h4000_0014);
    push("mp_id_suppress", 32'd0);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk(ex_redirect_pc);
    pop_chk({31'd0, id_target_taken});

    // pred_q cleared: stalled taken branch now mispredicts
    nxt();
    id_drv(1'b0, PC_A, br_a);
    ex_drv(1'b1, 1'b1, 1'b1, PC_A, T_A);
    push("flush_pred_clr", 32'd1);
    push("mp_cnt", 32'd2);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});

    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_A, br_a);
    push("wt_taken", 32'd1);
    @(negedge clk);
    pop_chk({31'd0, id_target_taken});

    // EX stall: pred_q held at 1, no training
    nxt();
    id_drv(1'b0, PC_A, br_a);
    ex_drv(1'b1, 1'b0, 1'b1, PC_A, T_A);
    for (int i = 0; i < 3; i++) begin
      push("stall_mispred", 32'd1);
      push("stall_cnt", 32'd2);
      @(negedge clk);
      pop_chk({31'd0, ex_br_mispred});
      pop_chk({30'd0, dut.u_bht.cnt_q[4]});
      nxt();
    end
    ex_drv(1'b1, 1'b0, 1'b0, PC_A, T_A);
    push("unstall_mispred", 32'd1);
    push("unstall_cnt_pre", 32'd2);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});

    // JAL / JALR / invalid JAL / negative branch offset
    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_B, jal_b);
    push("unstall_one_update", 32'd1);
    push("jal_target", 32'h4000_00F8);
    push("jal_taken", 32'd1);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk(id_target);
    pop_chk({31'd0, id_target_taken});

    nxt();
    id_drv(1'b1, PC_B, jalr_b);
    push("jalr_target", 32'h4000_0104);
    push("jalr_taken", 32'd0);
    @(negedge clk);
    pop_chk(id_target);
    pop_chk({31'd0, id_target_taken});

    nxt();
    id_drv(1'b0, PC_B, jal_b);
    push("jal_invalid_taken", 32'd0);
    @(negedge clk);
    pop_chk({31'd0, id_target_taken});

    nxt();
    id_drv(1'b1, PC_B, br_b);
    push("brneg_target", 32'h4000_00E0);
    push("brneg_taken", 32'd0);
    @(negedge clk);
    pop_chk(id_target);
    pop_chk({31'd0, id_target_taken});

    // Train index 0 up to strongly taken
    nxt();
    id_drv(1'b0, PC_B, br_b);
    ex_drv(1'b1, 1'b1, 1'b0, PC_B, 32'h4000_00E0);
    nxt();
    push("idx0_cnt", 32'd2);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[0]});
    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_B, 32'h4000_00E0);
    id_drv(1'b1, PC_B, br_b);
    push("idx0_taken", 32'd1);
    @(negedge clk);
    pop_chk({31'd0, id_target_taken});

    // Same-index read/write: ID sees the pre-update counter
    nxt();
    ex_drv(1'b1, 1'b1, 1'b0, PC_A, T_A);
    id_drv(1'b1, PC_A, br_a);
    push("nobyp_mispred", 32'd0);
    push("nobyp_taken", 32'd0);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({31'd0, id_target_taken});

    nxt();
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    push("nobyp_cnt_after", 32'd2);
    push("nobyp_taken_after", 32'd1);
    @(negedge clk);
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk({31'd0, id_target_taken});

    // Reset between edges with pred_q=1 and a trained table
    nxt();
    ex_drv(1'b1, 1'b0, 1'b1, PC_A, T_A);
    push("prerst_mispred", 32'd1);
    @(negedge clk);
    pop_chk({31'd0, ex_br_mispred});
    #2;
    rst_n = 1'b0;
    #1;
    push("midrst_mispred", 32'd0);
    push("midrst_cnt4", 32'd1);
    push("midrst_cnt0", 32'd1);
    push("midrst_taken", 32'd0);
    pop_chk({31'd0, ex_br_mispred});
    pop_chk({30'd0, dut.u_bht.cnt_q[4]});
    pop_chk({30'd0, dut.u_bht.cnt_q[0]});
    pop_chk({31'd0, id_target_taken});
`ifdef BP_STATS_EN
    push("midrst_stat_br", 32'd0);
    push("midrst_stat_mp", 32'd0);
    push("midrst_stat_jal", 32'd0);
    pop_chk(stat_branches);
    pop_chk(stat_mispred);
    pop_chk(stat_jal);
`endif

    nxt();
    rst_n = 1'b1;
    ex_drv(1'b0, 1'b0, 1'b0, PC_A, T_A);
    nxt();

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
